arcade_input_ctrl: RTL and testbench

Player-input conditioning stage between `hps_io` and the game core. It decodes the PS/2 key-event stream into per-player key states and merges them with the two MiSTer joysticks into registered player-control outputs. It debounces the coin sources and shapes each coin press into one fixed-width pulse. The outputs drive the core's `start1/start2/coin1/fire*/up*/down*/left*/right*` inputs directly.

---
 rtl/arcade_input_ctrl_if.sv | 22 ++
 rtl/arcade_input_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_ctrl_if.sv
// Player-input bundle between hps_io and the game core: PS/2 events and
// joysticks in, conditioned player controls and shaped coin pulse out.
interface arcade_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [4:0]  p1_ctl;
  logic [4:0]  p2_ctl;
  logic        start1;
  logic        start2;
  logic        coin;

  modport master (
    output ps2_key, joystick_0, joystick_1,
    input  p1_ctl, p2_ctl, start1, start2, coin
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1,
    output p1_ctl, p2_ctl, start1, start2, coin
  );
endinterface

// File: rtl/arcade_input_ctrl.sv
// PS/2 + joystick merge into registered player controls, coin debounce and
// fixed-width coin pulse. Optional autofire square wave under `AUTOFIRE_EN.
module arcade_input_ctrl #(
  parameter int DEBOUNCE_CYC   = 12000,
  parameter int COIN_PULSE_CYC = 1200000,
  parameter int AUTOFIRE_DIV   = 600000
) (
  input logic               clk_sys,
  input logic               reset,
  arcade_input_ctrl_if.slave io
);
  localparam int K_UP1 = 0, K_DOWN1 = 1, K_LEFT1 = 2, K_RIGHT1 = 3, K_FIRE1 = 4;
  localparam int K_START1 = 5, K_START2 = 6, K_COIN1 = 7, K_COIN2 = 8;
  localparam int K_UP2 = 9, K_DOWN2 = 10, K_LEFT2 = 11, K_RIGHT2 = 12, K_FIRE2 = 13;
  localparam int NKEY = 14;

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PC_W = (COIN_PULSE_CYC > 1) ? $clog2(COIN_PULSE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(COIN_PULSE_CYC - 1);

  // One-hot mask of the key-state bit an event targets; zero for unlisted codes.
  function automatic logic [NKEY-1:0] key_decode(input logic ext, input logic [7:0] code);
    logic [NKEY-1:0] m;
    m = '0;
    case (code)
      8'h75: m[K_UP1]    = 1'b1;
      8'h72: m[K_DOWN1]  = 1'b1;
      8'h6B: m[K_LEFT1]  = 1'b1;
      8'h74: m[K_RIGHT1] = 1'b1;
      8'h14: m[K_FIRE1]  = 1'b1;
      default: begin
        if (!ext) begin
          case (code)
            8'h29:        m[K_FIRE1]  = 1'b1;
            8'h05, 8'h16: m[K_START1] = 1'b1;
            8'h06, 8'h1E: m[K_START2] = 1'b1;
            8'h2E:        m[K_COIN1]  = 1'b1;
            8'h36:        m[K_COIN2]  = 1'b1;
            8'h2D:        m[K_UP2]    = 1'b1;
            8'h2B:        m[K_DOWN2]  = 1'b1;
            8'h23:        m[K_LEFT2]  = 1'b1;
            8'h34:        m[K_RIGHT2] = 1'b1;
            8'h1C:        m[K_FIRE2]  = 1'b1;
            default:      m = '0;
          endcase
        end
      end
    endcase
    return m;
  endfunction

  logic            old_tog_p0;
  logic [NKEY-1:0] kst_p0;
  logic [NKEY-1:0] kmask;
  logic [4:0]      p1_nxt, p2_nxt, p1_ctl_p1, p2_ctl_p1;
  logic            start1_p1, start2_p1;
  logic            fire1_src, fire2_src;

  assign kmask = key_decode(io.ps2_key[8], io.ps2_key[7:0]);

`ifdef AUTOFIRE_EN
  localparam int AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_DIV - 1);
  logic [AF_W-1:0] af_cnt;
  logic            af_sq;
  logic            unused_joy;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt <= '0;
      af_sq  <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt <= '0;
      af_sq  <= ~af_sq;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  assign fire1_src  = kst_p0[K_FIRE1] | io.joystick_0[4] | (io.joystick_0[8] & af_sq);
  assign fire2_src  = kst_p0[K_FIRE2] | io.joystick_1[4] | (io.joystick_1[8] & af_sq);
  assign unused_joy = &{1'b0, io.joystick_0[15:9], io.joystick_1[15:9]};
`else
  logic unused_joy;
  assign fire1_src  = kst_p0[K_FIRE1] | io.joystick_0[4];
  assign fire2_src  = kst_p0[K_FIRE2] | io.joystick_1[4];
  assign unused_joy = &{1'b0, io.joystick_0[15:8], io.joystick_1[15:8]};
`endif

  always_comb begin
    p1_nxt = {fire1_src, kst_p0[K_UP1], kst_p0[K_DOWN1], kst_p0[K_LEFT1], kst_p0[K_RIGHT1]};
    p2_nxt = {fire2_src, kst_p0[K_UP2], kst_p0[K_DOWN2], kst_p0[K_LEFT2], kst_p0[K_RIGHT2]};
    p1_nxt[3:0] = p1_nxt[3:0] | io.joystick_0[3:0];
    p2_nxt[3:0] = p2_nxt[3:0] | io.joystick_1[3:0];
  end

  // Stage p0: key-state registers updated from PS/2 toggle events
  always_ff @(posedge clk_sys) begin
    old_tog_p0 <= io.ps2_key[10];
    if (reset) begin
      kst_p0 <= '0;
    end else if (io.ps2_key[10] != old_tog_p0) begin
      kst_p0 <= (kst_p0 & ~kmask) | ({NKEY{io.ps2_key[9]}} & kmask);
    end
  end

  // Stage p1: merged output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p1_ctl_p1 <= '0;
      p2_ctl_p1 <= '0;
      start1_p1 <= 1'b0;
      start2_p1 <= 1'b0;
    end else begin
      p1_ctl_p1 <= p1_nxt;
      p2_ctl_p1 <= p2_nxt;
      start1_p1 <= kst_p0[K_START1] | io.joystick_0[5] | io.joystick_1[5];
      start2_p1 <= kst_p0[K_START2] | io.joystick_0[6] | io.joystick_1[6];
    end
  end

  logic            coin_raw, coin_db;
  logic [DB_W-1:0] db_cnt;

  assign coin_raw = kst_p0[K_COIN1] | kst_p0[K_COIN2] | io.joystick_0[7] | io.joystick_1[7];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      db_cnt  <= '0;
      coin_db <= 1'b0;
    end else if (coin_raw == coin_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt  <= '0;
      coin_db <= coin_raw;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_REL} coin_state_t;
  coin_state_t     state, state_nxt;
  logic [PC_W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic            coin_out;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      pulse_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_cnt_nxt;
    end
  end

  // IDLE is only reachable with coin_db low, so a high level here is its rising edge.
  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    coin_out      = 1'b0;
    case (state)
      S_IDLE: begin
        if (coin_db) begin
          state_nxt     = S_PULSE;
          pulse_cnt_nxt = '0;
        end
      end
      S_PULSE: begin
        coin_out = 1'b1;
        if (pulse_cnt == PC_LAST) begin
          state_nxt     = S_WAIT_REL;
          pulse_cnt_nxt = '0;
        end else begin
          pulse_cnt_nxt = pulse_cnt + 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (!coin_db) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign io.p1_ctl = p1_ctl_p1;
  assign io.p2_ctl = p2_ctl_p1;
  assign io.start1 = start1_p1;
  assign io.start2 = start2_p1;
  assign io.coin   = coin_out;
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Randomized and directed bench for arcade_input_ctrl against a name-keyed
// behavioural model of key states, debounced coin and pulse timing.
module tb_arcade_input_ctrl;
  localparam int DB  = 4;
  localparam int PW  = 10;
  localparam int AFD = 8;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl_if io();

  arcade_input_ctrl #(
    .DEBOUNCE_CYC  (DB),
    .COIN_PULSE_CYC(PW),
    .AUTOFIRE_DIV  (AFD)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .io     (io)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: key states held by name, coin as remaining pulse cycles.
  bit         key_down[string];
  logic       m_old_tog;
  logic [4:0] m_p1, m_p2;
  logic       m_s1, m_s2, m_db;
  int         m_db_run, m_rem, m_edges;
  bit         m_blocked;

  function automatic string key_name(input logic ext, input logic [7:0] code);
    case (code)
      8'h75: return "up1";
      8'h72: return "down1";
      8'h6B: return "left1";
      8'h74: return "right1";
      8'h14: return "fire1";
      default: ;
    endcase
    if (ext) return "";
    case (code)
      8'h29: return "fire1";
      8'h05, 8'h16: return "start1";
      8'h06, 8'h1E: return "start2";
      8'h2E: return "coin1";
      8'h36: return "coin2";
      8'h2D: return "up2";
      8'h2B: return "down2";
      8'h23: return "left2";
      8'h34: return "right2";
      8'h1C: return "fire2";
      default: return "";
    endcase
  endfunction

  function automatic bit kd(input string nm);
    return key_down.exists(nm) ? key_down[nm] : 1'b0;
  endfunction

  task automatic model_edge();
    logic [15:0] j0, j1;
    bit af_old, f1, f2, raw, db_old;
    string nm;
    j0 = io.joystick_0;
    j1 = io.joystick_1;
    if (reset) begin
      key_down.delete();
      m_old_tog = io.ps2_key[10];
      m_p1 = '0; m_p2 = '0; m_s1 = 0; m_s2 = 0;
      m_db = 0; m_db_run = 0; m_rem = 0; m_blocked = 0; m_edges = 0;
      return;
    end
`ifdef AUTOFIRE_EN
    af_old = ((m_edges / AFD) % 2) == 1;
`else
    af_old = 0;
`endif
    f1 = kd("fire1") | j0[4] | (j0[8] & af_old);
    f2 = kd("fire2") | j1[4] | (j1[8] & af_old);
    m_p1 = {f1, kd("up1") | j0[3], kd("down1") | j0[2], kd("left1") | j0[1], kd("right1") | j0[0]};
    m_p2 = {f2, kd("up2") | j1[3], kd("down2") | j1[2], kd("left2") | j1[1], kd("right2") | j1[0]};
    m_s1 = kd("start1") | j0[5] | j1[5];
    m_s2 = kd("start2") | j0[6] | j1[6];
    raw  = kd("coin1") | kd("coin2") | j0[7] | j1[7];
    db_old = m_db;
    if (m_rem > 0) m_rem--;
    else if (m_blocked) begin
      if (!db_old) m_blocked = 0;
    end else if (db_old) begin
      m_rem = PW;
      m_blocked = 1;
    end
    if (raw == m_db) m_db_run = 0;
    else begin
      m_db_run++;
      if (m_db_run == DB) begin
        m_db = raw;
        m_db_run = 0;
      end
    end
    if (io.ps2_key[10] != m_old_tog) begin
      nm = key_name(io.ps2_key[8], io.ps2_key[7:0]);
      if (nm != "") key_down[nm] = io.ps2_key[9];
    end
    m_old_tog = io.ps2_key[10];
    m_edges++;
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    check_eq("p1_ctl", io.p1_ctl, m_p1);
    check_eq("p2_ctl", io.p2_ctl, m_p2);
    check_eq("start1", io.start1, m_s1);
    check_eq("start2", io.start2, m_s2);
    check_eq("coin",   io.coin, m_rem > 0);
  endtask

  task automatic ps2_send(input logic pressed, input logic ext, input logic [7:0] code);
    io.ps2_key = {~io.ps2_key[10], pressed, ext, code};
  endtask

  logic [7:0] codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16, 8'h06, 8'h1E,
                             8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h11, 8'h5A, 8'h00};

  initial begin
    int lat, hi, tog, wait_n;
    logic prev;
    reset = 1'b1;
    io.ps2_key = '0;
    io.joystick_0 = '0;
    io.joystick_1 = '0;
    repeat (3) step();
    check_eq("rst_p1", io.p1_ctl, 5'd0);
    check_eq("rst_coin", io.coin, 1'b0);
    reset = 1'b0;
    repeat (2) step();

    // PS/2 press/release of up1: two-edge latency
    ps2_send(1'b1, 1'b0, 8'h75);
    step();
    check_eq("up1_lat1", io.p1_ctl[3], 1'b0);
    step();
    check_eq("up1_press", io.p1_ctl[3], 1'b1);
    ps2_send(1'b0, 1'b0, 8'h75);
    repeat (2) step();
    check_eq("up1_release", io.p1_ctl[3], 1'b0);

    // Back-to-back events are both applied
    ps2_send(1'b1, 1'b1, 8'h6B);
    step();
    ps2_send(1'b1, 1'b0, 8'h74);
    repeat (2) step();
    check_eq("b2b_left_right", io.p1_ctl[1:0], 2'b11);
    ps2_send(1'b0, 1'b0, 8'h6B);
    step();
    ps2_send(1'b0, 1'b0, 8'h74);
    repeat (2) step();

    io.joystick_1 = 16'h0010;
    step();
    check_eq("joy1_fire", io.p2_ctl[4], 1'b1);
    check_eq("joy1_p1_quiet", io.p1_ctl, 5'd0);
    io.joystick_1 = '0;
    step();

    // Held coin: one pulse, latency DB+1, width PW
    io.joystick_0 = 16'h0080;
    lat = 0; hi = 0;
    for (int i = 1; i <= 3 * PW; i++) begin
      step();
      if (io.coin && lat == 0) lat = i;
      if (io.coin) hi++;
    end
    check_eq("coin_lat", lat, DB + 1);
    check_eq("coin_width", hi, PW);
    io.joystick_0 = '0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin step(); if (io.coin) hi++; end
    check_eq("coin_release_quiet", hi, 0);
    io.joystick_0 = 16'h0080;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin step(); if (io.coin) lat = i; end
    check_eq("coin_repress_lat", lat, DB + 1);
    repeat (PW + 2) step();
    io.joystick_0 = '0;
    repeat (10) step();

    // Glitch shorter than the debounce window
    io.joystick_0 = 16'h0080;
    hi = 0;
    for (int i = 0; i < DB - 1; i++) begin step(); if (io.coin) hi++; end
    io.joystick_0 = '0;
    for (int i = 0; i < 20; i++) begin step(); if (io.coin) hi++; end
    check_eq("coin_glitch", hi, 0);

    // Reset in the middle of a pulse with coin held
    io.joystick_0 = 16'h0080;
    wait_n = 0;
    while (!io.coin && wait_n < 30) begin step(); wait_n++; end
    check_eq("coin_seen_before_reset", io.coin, 1'b1);
    repeat (4) step();
    reset = 1'b1;
    step();
    check_eq("coin_reset_drop", io.coin, 1'b0);
    reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin step(); if (io.coin) lat = i; end
    check_eq("coin_after_reset_lat", lat, DB + 1);
    repeat (PW + 2) step();
    io.joystick_0 = '0;
    repeat (10) step();

    // Autofire bit held
    io.joystick_0 = 16'h0100;
    repeat (2) step();
    prev = io.p1_ctl[4];
    tog = 0; hi = 0;
    for (int i = 0; i < 4 * AFD; i++) begin
      step();
      if (io.p1_ctl[4] != prev) tog++;
      if (io.p1_ctl[4]) hi++;
      prev = io.p1_ctl[4];
    end
`ifdef AUTOFIRE_EN
    check_eq("autofire_toggles", tog, 4);
`else
    check_eq("autofire_off", hi, 0);
`endif
    io.joystick_0 = '0;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0)
        ps2_send(1'($urandom), ($urandom_range(0, 3) == 0), codes[$urandom_range(0, 19)]);
      if ($urandom_range(0, 7) == 0)
        io.joystick_0 = {$urandom} & 16'hFF7F | (io.joystick_0 & 16'h0080);
      if ($urandom_range(0, 7) == 0)
        io.joystick_1 = {$urandom} & 16'hFF7F | (io.joystick_1 & 16'h0080);
      if ($urandom_range(0, 24) == 0) io.joystick_0[7] = ~io.joystick_0[7];
      if ($urandom_range(0, 24) == 0) io.joystick_1[7] = ~io.joystick_1[7];
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
